fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Front-end sequencer that owns the fetch PC register and selects next-PC from five sources: trap, mispredict recovery, BTB prediction, sequential PC+4, and a frozen PC while stalled.
- Consumes the branch predictor's hit/target and resolution outputs, and drives the pipeline kill signals.
- Runs a BTB invalidation sweep, one entry per cycle, after reset and on fence.i/security-domain flush requests; fetch is held for the duration.

Parameters:
- RESET_VEC, 32'h0000_0000, fetch address after reset and sweep.
- BTB_ENTRIES, 32, number of predictor entries to invalidate; power of 2.
- IDX_W, 5, log2(BTB_ENTRIES).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- stall_i  in  1  IF stall (I-side miss / hazard)
- hit_i  in  1  predictor hit for current pc_o
- predicted_pc_i  in  32  predictor target for pc_o
- ex_valid_i  in  1  EX stage holds a valid instruction
- pc_ex_i  in  32  PC of EX instruction
- wrong_predicted_i  in  2  01 = predicted taken, not taken; 10 = not-taken/wrong-target, taken; 00/11 = none
- alu_pc_i  in  32  resolved branch/jump target
- trap_i  in  1  trap/exception redirect request
- trap_pc_i  in  32  trap handler address
- flush_req_i  in  1  fence.i / domain-switch in EX; qualified by ex_valid_i
- pc_o  out  32  fetch PC register
- fetch_valid_o  out  1  IF may issue fetch at pc_o
- flush_if_id_o  out  1  kill IF/ID (combinational)
- flush_id_ex_o  out  1  kill ID/EX (combinational)
- btb_inv_o  out  1  invalidate predictor entry btb_inv_idx_o this cycle
- btb_inv_idx_o  out  IDX_W  entry being invalidated
- sweep_busy_o  out  1  state == SWEEP
- mispredict_cnt_o  out  16  saturating mispredict counter

Behaviour:
- Reset (async): pc_o = RESET_VEC; state = SWEEP; idx = 0; resume_pc = RESET_VEC; mispredict_cnt_o = 0; fetch_valid_o = 0; btb_inv_o = 1 from the first post-reset cycle.
- States: RUN, SWEEP.
- SWEEP:
  - btb_inv_o = 1, btb_inv_idx_o = idx, idx += 1 each cycle.
  - fetch_valid_o = 0, pc_o holds.
  - wrong_predicted_i, flush_req_i and stall_i are ignored; the counter does not change.
  - When idx == BTB_ENTRIES-1: that entry is invalidated, then next cycle state = RUN, pc_o = resume_pc, idx = 0. A sweep therefore takes exactly BTB_ENTRIES cycles.
  - trap_i during SWEEP: resume_pc <= trap_pc_i. The sweep is not shortened. flush_if_id_o and flush_id_ex_o are asserted for that cycle.
- RUN: fetch_valid_o = 1, btb_inv_o = 0. Priority per cycle, highest first:
  - 1. trap_i: pc_o <= trap_pc_i; assert both flushes. A coincident flush_req_i or mispredict is dropped.
  - 2. ex_valid_i & flush_req_i: assert both flushes; resume_pc <= pc_ex_i+4; idx <= 0; state <= SWEEP. Wins over a mispredict in the same cycle.
  - 3. ex_valid_i & wrong_predicted_i == 01: pc_o <= pc_ex_i+4; assert both flushes; counter += 1.
  - 4. ex_valid_i & wrong_predicted_i == 10: pc_o <= alu_pc_i; assert both flushes; counter += 1.
  - 5. stall_i: pc_o holds.
  - 6. hit_i: pc_o <= predicted_pc_i.
  - 7. otherwise: pc_o <= pc_o + 4.
- Cases 1–4 override stall_i.
- wrong_predicted_i == 11 is treated as 00.
- Arithmetic: +4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- The counter saturates at 16'hFFFF and is reset only by rst_i.
- Flush outputs are combinational from the current-cycle inputs and state. They are 0 in SWEEP except in a trap cycle.
- rst_i asserted mid-sweep restarts the sweep at idx 0 with resume_pc = RESET_VEC.

Test Plan:
- Reset release, no other stimulus -> btb_inv_o = 1 for exactly 32 cycles with idx 0..31 in order, fetch_valid_o = 0 throughout; next cycle pc_o = 0, fetch_valid_o = 1; then pc_o = 4, 8, 12...
- RUN at pc_o = 0x100, hit_i = 1, predicted_pc_i = 0x200 -> next pc_o = 0x200; with stall_i = 1 instead -> pc_o stays 0x100.
- ex_valid_i = 1, wrong_predicted_i = 10, alu_pc_i = 0x400, stall_i = 1 -> flush_if_id_o = flush_id_ex_o = 1 that cycle; next pc_o = 0x400; counter = 1. Then wrong_predicted_i = 01, pc_ex_i = 0x3F0 -> next pc_o = 0x3F4; counter = 2.
- flush_req_i with pc_ex_i = 0x80 plus a same-cycle wrong_predicted_i = 10 -> SWEEP entered, counter unchanged; after 32 invalidate cycles pc_o = 0x84. Trap_i with trap_pc_i = 0x1C0 at sweep cycle 10 -> sweep still lasts 32 cycles, then resume at 0x1C0.
- pc_o = 0xFFFF_FFFC, no hit -> next pc_o = 0; force the counter to 0xFFFF and inject a mispredict -> it stays 0xFFFF.
- rst_i pulsed at sweep cycle 20 -> idx restarts at 0; full 32-cycle sweep; resume at RESET_VEC.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: owns the fetch PC, picks the next PC from trap,
// mispredict recovery, predictor target, PC+4 or hold, drives the
// pipeline kill signals, and sweeps the predictor clean after reset
// and on fence.i / domain-switch flushes while fetch is held off.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 32,
    parameter int          IDX_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             hit_i,
    input  logic [31:0]      predicted_pc_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      pc_ex_i,
    input  logic [1:0]       wrong_predicted_i,
    input  logic [31:0]      alu_pc_i,
    input  logic             trap_i,
    input  logic [31:0]      trap_pc_i,
    input  logic             flush_req_i,
    output logic [31:0]      pc_o,
    output logic             fetch_valid_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             btb_inv_o,
    output logic [IDX_W-1:0] btb_inv_idx_o,
    output logic             sweep_busy_o,
    output logic [15:0]      mispredict_cnt_o
);

    localparam logic             STATE_RUN   = 1'b0;
    localparam logic             STATE_SWEEP = 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BTB_ENTRIES - 1);

    logic             state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      resume_pc;
    logic [31:0]      pc;
    logic [15:0]      mispredict_cnt;

    logic             in_run;
    logic             take_flush_req;
    logic             take_mp_not_taken;
    logic             take_mp_taken;
    logic             kill;
    logic [31:0]      pc_ex_plus4;

    assign pc_ex_plus4 = pc_ex_i + 32'd4;

    // Resolve which RUN-state redirect wins this cycle; lower priority
    // requests are masked by any higher one so only one path fires.
    always_comb begin
        in_run            = (state == STATE_RUN);
        take_flush_req    = 1'b0;
        take_mp_not_taken = 1'b0;
        take_mp_taken     = 1'b0;
        if (in_run && !trap_i && ex_valid_i) begin
            if (flush_req_i) begin
                take_flush_req = 1'b1;
            end else if (wrong_predicted_i == 2'b01) begin
                take_mp_not_taken = 1'b1;
            end else if (wrong_predicted_i == 2'b10) begin
                take_mp_taken = 1'b1;
            end
        end
        kill = trap_i | take_flush_req | take_mp_not_taken | take_mp_taken;
    end

    // Sequencer state, sweep index, resume address and fetch PC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= STATE_SWEEP;
            idx       <= '0;
            resume_pc <= RESET_VEC;
            pc        <= RESET_VEC;
        end else if (state == STATE_SWEEP) begin
            if (trap_i) begin
                resume_pc <= trap_pc_i;
            end
            if (idx == IDX_LAST) begin
                state <= STATE_RUN;
                idx   <= '0;
                pc    <= trap_i ? trap_pc_i : resume_pc;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            if (trap_i) begin
                pc <= trap_pc_i;
            end else if (take_flush_req) begin
                resume_pc <= pc_ex_plus4;
                idx       <= '0;
                state     <= STATE_SWEEP;
            end else if (take_mp_not_taken) begin
                pc <= pc_ex_plus4;
            end else if (take_mp_taken) begin
                pc <= alu_pc_i;
            end else if (stall_i) begin
                pc <= pc;
            end else if (hit_i) begin
                pc <= predicted_pc_i;
            end else begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Saturating count of resolved mispredicts that actually redirected fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mispredict_cnt <= '0;
        end else if ((take_mp_not_taken || take_mp_taken) && mispredict_cnt != 16'hFFFF) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

    assign pc_o             = pc;
    assign fetch_valid_o    = in_run;
    assign btb_inv_o        = !in_run;
    assign btb_inv_idx_o    = idx;
    assign sweep_busy_o     = !in_run;
    assign flush_if_id_o    = kill;
    assign flush_id_ex_o    = kill;
    assign mispredict_cnt_o = mispredict_cnt;

endmodule
